rob_ctrl: RTL and testbench
===========================

ROB_CTRL -- requirements
Module: rob_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR, default 4, index width; DEPTH, default 1<<ADDR, entry count.
REQ-002 clk  input  1  clock; reset asynchronous, active-low.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 flush  input  1  synchronous pipeline flush, discards all entries.
REQ-005 disp_valid_0, disp_valid_1  input  1 each  dispatch requests, slot 0 older.
REQ-006 disp_ready  output  1  at least 2 free entries.
REQ-007 disp_tag_0, disp_tag_1  output  ADDR each  indices allocated to slots 0/1 (tail, tail+1).
REQ-008 wr_en_0, wr_en_1  output  1 each  storage write strobes, equal to accepted dispatch per slot.
REQ-009 addr_in_0, addr_in_1  output  ADDR each  storage write indices, equal to disp_tag_0/1.
REQ-010 cmpl_valid  input  1  execution-complete strobe; cmpl_tag  input  ADDR  completing entry.
REQ-011 commit_ready  input  1  retire stage accepts offered commits.
REQ-012 commit_valid_0, commit_valid_1  output  1 each  head / head+1 retirable.
REQ-013 addr_out_0, addr_out_1  output  ADDR each  storage read indices, head and head+1; o_en_0, o_en_1  output  1 each, equal to commit_valid_0/1.
REQ-014 count  output  ADDR+1  occupied entries; full, empty  output  1 each.

Function
REQ-015 Pointers head, tail SHALL be ADDR bits, wrapping modulo DEPTH; count SHALL be ADDR+1 bits, range 0..DEPTH.
REQ-016 disp_ready SHALL be combinational: (DEPTH - count) >= 2.
REQ-017 Slot 0 SHALL be accepted when disp_valid_0 && disp_ready && !flush; slot 1 only when slot 0 is accepted and disp_valid_1; disp_valid_1 alone SHALL be ignored.
REQ-018 Accepted dispatch SHALL, at the next edge, set alloc[idx]=1 and done[idx]=0, and advance tail by the number accepted (0/1/2).
REQ-019 cmpl_valid SHALL set done[cmpl_tag] at the next edge only if alloc[cmpl_tag]=1; completion to an unallocated entry SHALL be ignored.
REQ-020 commit_valid_0 SHALL be !empty && done[head]; commit_valid_1 SHALL be commit_valid_0 && count>=2 && done[head+1].
REQ-021 When commit_ready is high, each asserted commit_valid SHALL retire its entry: clear alloc, advance head by 0/1/2.
REQ-022 Same-cycle dispatch and commit SHALL update count = count + n_disp - n_commit; no transient full/empty.
REQ-023 Completion to the head entry in the cycle it becomes visible SHALL make commit_valid_0 rise the following cycle (one-cycle completion-to-commit latency).
REQ-024 Completion and commit of the same tag in one cycle SHALL leave done cleared with the entry freed.
REQ-025 full SHALL be count==DEPTH; empty SHALL be count==0; both combinational from registered count.
REQ-026 flush SHALL take priority over dispatch, completion, and commit: next cycle head=tail=0, count=0, all alloc/done cleared; wr_en_0/1 SHALL be 0 during flush.
REQ-027 Dispatch and commit SHALL be in-order; no entry retires before an older one.

Reset
REQ-028 On reset low, head, tail, count SHALL be 0 and all alloc/done bits cleared, asynchronously.
REQ-029 During and after reset, outputs SHALL read: disp_ready=1, disp_tag_0=0, disp_tag_1=1, wr_en=0, commit_valid=0, o_en=0, count=0, empty=1, full=0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight entries without a commit pulse.

Structure
REQ-031 ROB_ADDR, ROB_DEPTH and typedef rob_tag_t (ADDR bits) SHALL live in shared package rob_pkg.
REQ-032 One sub-module, rob_ptr (wrapping pointer with increment 0/1/2, synchronous clear), SHALL be instantiated for head and tail.
REQ-033 Payload storage SHALL be external; rob_ctrl holds only pointers, count, alloc and done vectors.

Verification
REQ-034 Reset, then dispatch 2 per cycle for 7 cycles -> tags 0..13, count=14, disp_ready=1; 8th request -> tags 14,15, full=1, disp_ready=0 next cycle.
REQ-035 Fill to 16, complete tags 1 then 0, commit_ready=1 -> one cycle later commit_valid_0=1 and commit_valid_1=1, head=2, count=14.
REQ-036 head=15, tail=15, count=0; dispatch 2 -> tags 15,0 and tail=1; complete both, commit -> head=1 (wrap-around).
REQ-037 count=10: dispatch 2 and commit 2 in the same cycle -> count stays 10, full=0, empty=0.
REQ-038 cmpl_valid to unallocated tag 9 with count=3 -> done[9] stays 0; dispatch later reaching tag 9 -> commit_valid_0 not asserted until completion.
REQ-039 flush with count=12 while dispatching 2 -> next cycle count=0, head=tail=0, empty=1, no wr_en; reset low mid-commit -> no commit pulse.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared reorder-buffer sizing and tag type for the ROB control slice.
package rob_pkg;
  localparam int ROB_ADDR  = 4;
  localparam int ROB_DEPTH = 1 << ROB_ADDR;

  typedef logic [ROB_ADDR-1:0] rob_tag_t;
endpackage

// File: rtl/rob_ptr.sv
// Wrapping ROB pointer: advances by 0/1/2 per cycle, wraps modulo 2**ADDR, synchronous clear.
module rob_ptr #(
  parameter int ADDR = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_clr,
  input  logic [1:0]      i_inc,
  output logic [ADDR-1:0] o_ptr
);
  logic [ADDR-1:0] r_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= r_ptr + ADDR'(i_inc);
    end
  end

  assign o_ptr = r_ptr;
endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer control: two-wide in-order dispatch and commit with out-of-order completion.
// Payload storage is external; this block only tracks pointers, occupancy and per-entry state.
module rob_ctrl
  import rob_pkg::*;
#(
  parameter int ADDR  = ROB_ADDR,
  parameter int DEPTH = 1 << ADDR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            disp_valid_0,
  input  logic            disp_valid_1,
  output logic            disp_ready,
  output logic [ADDR-1:0] disp_tag_0,
  output logic [ADDR-1:0] disp_tag_1,
  output logic            wr_en_0,
  output logic            wr_en_1,
  output logic [ADDR-1:0] addr_in_0,
  output logic [ADDR-1:0] addr_in_1,
  input  logic            cmpl_valid,
  input  logic [ADDR-1:0] cmpl_tag,
  input  logic            commit_ready,
  output logic            commit_valid_0,
  output logic            commit_valid_1,
  output logic [ADDR-1:0] addr_out_0,
  output logic [ADDR-1:0] addr_out_1,
  output logic            o_en_0,
  output logic            o_en_1,
  output logic [ADDR:0]   count,
  output logic            full,
  output logic            empty
);
  localparam logic [ADDR:0] DEPTH_W = (ADDR+1)'(DEPTH);

  logic [ADDR-1:0]  w_head, w_tail, w_head1, w_tail1;
  logic [ADDR:0]    r_count, w_free;
  logic [DEPTH-1:0] r_alloc, r_done, w_alloc_nx, w_done_nx;
  logic             w_ready, w_acc0, w_acc1, w_cv0, w_cv1, w_ret0, w_ret1, w_empty;
  logic [1:0]       w_n_disp, w_n_cmt;

  assign w_head1 = w_head + ADDR'(1);
  assign w_tail1 = w_tail + ADDR'(1);
  assign w_empty = (r_count == '0);
  assign w_free  = DEPTH_W - r_count;
  assign w_ready = (w_free >= (ADDR+1)'(2));

  // Slot 1 can only ride along with slot 0, which keeps allocation in order.
  assign w_acc0   = disp_valid_0 && w_ready && !flush;
  assign w_acc1   = w_acc0 && disp_valid_1;
  assign w_n_disp = {w_acc1, w_acc0 ^ w_acc1};

  assign w_cv0   = !w_empty && r_done[w_head];
  assign w_cv1   = w_cv0 && (r_count >= (ADDR+1)'(2)) && r_done[w_head1];
  assign w_ret0  = commit_ready && w_cv0;
  assign w_ret1  = commit_ready && w_cv1;
  assign w_n_cmt = {w_ret1, w_ret0 ^ w_ret1};

  rob_ptr #(.ADDR(ADDR)) u_head (
    .clk   (clk),
    .reset (reset),
    .i_clr (flush),
    .i_inc (w_n_cmt),
    .o_ptr (w_head)
  );

  rob_ptr #(.ADDR(ADDR)) u_tail (
    .clk   (clk),
    .reset (reset),
    .i_clr (flush),
    .i_inc (w_n_disp),
    .o_ptr (w_tail)
  );

  // Commit clears after completion so a same-cycle complete+retire leaves the entry clean.
  always_comb begin
    w_alloc_nx = r_alloc;
    w_done_nx  = r_done;
    if (cmpl_valid && r_alloc[cmpl_tag]) w_done_nx[cmpl_tag] = 1'b1;
    if (w_ret0) begin
      w_alloc_nx[w_head] = 1'b0;
      w_done_nx[w_head]  = 1'b0;
    end
    if (w_ret1) begin
      w_alloc_nx[w_head1] = 1'b0;
      w_done_nx[w_head1]  = 1'b0;
    end
    if (w_acc0) begin
      w_alloc_nx[w_tail] = 1'b1;
      w_done_nx[w_tail]  = 1'b0;
    end
    if (w_acc1) begin
      w_alloc_nx[w_tail1] = 1'b1;
      w_done_nx[w_tail1]  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_alloc <= '0;
      r_done  <= '0;
    end else if (flush) begin
      r_count <= '0;
      r_alloc <= '0;
      r_done  <= '0;
    end else begin
      r_count <= r_count + (ADDR+1)'(w_n_disp) - (ADDR+1)'(w_n_cmt);
      r_alloc <= w_alloc_nx;
      r_done  <= w_done_nx;
    end
  end

  assign disp_ready     = w_ready;
  assign disp_tag_0     = w_tail;
  assign disp_tag_1     = w_tail1;
  assign wr_en_0        = w_acc0;
  assign wr_en_1        = w_acc1;
  assign addr_in_0      = w_tail;
  assign addr_in_1      = w_tail1;
  assign commit_valid_0 = w_cv0;
  assign commit_valid_1 = w_cv1;
  assign o_en_0         = w_cv0;
  assign o_en_1         = w_cv1;
  assign addr_out_0     = w_head;
  assign addr_out_1     = w_head1;
  assign count          = r_count;
  assign full           = (r_count == DEPTH_W);
  assign empty          = w_empty;
endmodule

// File: tb/tb_rob_ctrl.sv
// Bench for rob_ctrl: directed scenarios plus random traffic against a queue-based ROB model.
module tb_rob_ctrl;
  import rob_pkg::*;
  localparam int A = ROB_ADDR;
  localparam int D = ROB_DEPTH;

  logic clk = 1'b0;
  logic reset, flush, disp_valid_0, disp_valid_1, cmpl_valid, commit_ready;
  logic [A-1:0] cmpl_tag;
  logic disp_ready, wr_en_0, wr_en_1, commit_valid_0, commit_valid_1, o_en_0, o_en_1, full, empty;
  logic [A-1:0] disp_tag_0, disp_tag_1, addr_in_0, addr_in_1, addr_out_0, addr_out_1;
  logic [A:0] count;

  rob_ctrl #(.ADDR(A), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid_0(disp_valid_0), .disp_valid_1(disp_valid_1), .disp_ready(disp_ready),
    .disp_tag_0(disp_tag_0), .disp_tag_1(disp_tag_1),
    .wr_en_0(wr_en_0), .wr_en_1(wr_en_1), .addr_in_0(addr_in_0), .addr_in_1(addr_in_1),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .commit_ready(commit_ready),
    .commit_valid_0(commit_valid_0), .commit_valid_1(commit_valid_1),
    .addr_out_0(addr_out_0), .addr_out_1(addr_out_1), .o_en_0(o_en_0), .o_en_1(o_en_1),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: program-order queue of live tags plus per-tag done flags.
  int q[$];
  bit m_alloc[D];
  bit m_done[D];
  int m_head, m_tail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit e_ready();
    return (D - q.size()) >= 2;
  endfunction

  function automatic bit e_cv0();
    return q.size() > 0 && m_done[q[0]];
  endfunction

  function automatic bit e_cv1();
    return e_cv0() && q.size() >= 2 && m_done[q[1]];
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < D; i++) begin
      m_alloc[i] = 1'b0;
      m_done[i]  = 1'b0;
    end
    m_head = 0;
    m_tail = 0;
  endtask

  task automatic check_outputs();
    bit a0, a1;
    a0 = reset && disp_valid_0 && e_ready() && !flush;
    a1 = a0 && disp_valid_1;
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == D));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("disp_ready", 32'(disp_ready), 32'(e_ready()));
    chk("disp_tag_0", 32'(disp_tag_0), 32'(m_tail));
    chk("disp_tag_1", 32'(disp_tag_1), 32'((m_tail + 1) % D));
    chk("addr_in_0", 32'(addr_in_0), 32'(m_tail));
    chk("addr_in_1", 32'(addr_in_1), 32'((m_tail + 1) % D));
    chk("wr_en_0", 32'(wr_en_0), 32'(a0));
    chk("wr_en_1", 32'(wr_en_1), 32'(a1));
    chk("commit_valid_0", 32'(commit_valid_0), 32'(e_cv0()));
    chk("commit_valid_1", 32'(commit_valid_1), 32'(e_cv1()));
    chk("o_en_0", 32'(o_en_0), 32'(e_cv0()));
    chk("o_en_1", 32'(o_en_1), 32'(e_cv1()));
    chk("addr_out_0", 32'(addr_out_0), 32'(m_head));
    chk("addr_out_1", 32'(addr_out_1), 32'((m_head + 1) % D));
  endtask

  task automatic model_edge();
    bit a0, a1, c0, c1;
    int t;
    if (flush) begin
      model_reset();
    end else begin
      a0 = disp_valid_0 && e_ready();
      a1 = a0 && disp_valid_1;
      c0 = commit_ready && e_cv0();
      c1 = commit_ready && e_cv1();
      if (cmpl_valid && m_alloc[int'(cmpl_tag)]) m_done[int'(cmpl_tag)] = 1'b1;
      for (int k = 0; k < int'(c0) + int'(c1); k++) begin
        t = q.pop_front();
        m_alloc[t] = 1'b0;
        m_done[t]  = 1'b0;
        m_head = (m_head + 1) % D;
      end
      for (int k = 0; k < int'(a0) + int'(a1); k++) begin
        q.push_back(m_tail);
        m_alloc[m_tail] = 1'b1;
        m_done[m_tail]  = 1'b0;
        m_tail = (m_tail + 1) % D;
      end
    end
  endtask

  task automatic drive(input bit v0, input bit v1, input bit cv, input int ct,
                       input bit cr, input bit fl);
    disp_valid_0 = v0;
    disp_valid_1 = v1;
    cmpl_valid   = cv;
    cmpl_tag     = A'(ct);
    commit_ready = cr;
    flush        = fl;
  endtask

  // One cycle: settle, compare, clock, advance model.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b1;

    // Fill two per cycle; the eighth request reaches full.
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      step();
      if (i == 6) chk("count_after_7", 32'(count), 32'd14);
    end
    drive(1, 1, 0, 0, 0, 0);
    step();
    chk("full_at_16", 32'(full), 32'd1);

    // Out-of-order completion, then pair retire.
    drive(0, 0, 1, 1, 1, 0);
    step();
    drive(0, 0, 1, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 1, 0);
    chk("cv0_pair", 32'(commit_valid_0), 32'd1);
    chk("cv1_pair", 32'(commit_valid_1), 32'd1);
    step();
    chk("head_after_pair", 32'(addr_out_0), 32'd2);
    chk("count_after_pair", 32'(count), 32'd14);

    // Walk pointers to 15 with an empty ROB, then wrap.
    drive(0, 0, 0, 0, 0, 1);
    step();
    for (int i = 0; i < 15; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      step();
      drive(0, 0, 1, q[q.size()-1], 0, 0);
      step();
      drive(0, 0, 0, 0, 1, 0);
      step();
    end
    drive(1, 1, 0, 0, 0, 0);
    step();
    drive(0, 0, 1, 15, 0, 0);
    step();
    drive(0, 0, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 1, 0);
    step();
    chk("head_wrapped", 32'(addr_out_0), 32'd1);

    // Hold count at 10 across a simultaneous dispatch-2/commit-2.
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 1, q[0], 0, 0);
    step();
    drive(0, 0, 1, q[1], 0, 0);
    step();
    drive(1, 1, 0, 0, 1, 0);
    step();
    chk("count_held_10", 32'(count), 32'd10);

    // Completion to an unallocated tag must not stick.
    drive(0, 0, 0, 0, 0, 1);
    step();
    drive(1, 1, 0, 0, 0, 0);
    step();
    drive(1, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 1, 9, 0, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      step();
    end
    for (int i = 0; i < 40 && m_head != 9; i++) begin
      drive(0, 0, 1, q[0], 1, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("tag9_not_done", 32'(commit_valid_0), 32'd0);
    drive(0, 0, 1, 9, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("tag9_done", 32'(commit_valid_0), 32'd1);
    step();

    // Flush while dispatching with twelve live entries.
    drive(0, 0, 0, 0, 0, 1);
    step();
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      step();
    end
    chk("count_12", 32'(count), 32'd12);
    drive(1, 1, 0, 0, 0, 1);
    #1;
    chk("flush_wr_en_0", 32'(wr_en_0), 32'd0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    step();

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      int ct;
      if (q.size() > 0 && $urandom_range(3) != 0) ct = q[$urandom_range(q.size() - 1)];
      else ct = int'($urandom_range(D - 1));
      drive(bit'($urandom_range(3) != 0), bit'($urandom_range(1)), bit'($urandom_range(1)),
            ct, bit'($urandom_range(2) != 0), bit'($urandom_range(63) == 0));
      step();
    end

    // Reset dropped while a commit is being offered.
    drive(0, 0, 0, 0, 0, 1);
    step();
    drive(1, 1, 0, 0, 0, 0);
    step();
    drive(0, 0, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 1, 0);
    #1;
    chk("pre_reset_cv0", 32'(commit_valid_0), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    chk("reset_no_commit", 32'(commit_valid_0), 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
